vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
Reader side of the frame buffer. The rasterizer fills the buffer; this block scans it out as 640x480@60 VGA.
- Generates the horizontal/vertical pixel counters and issues synchronous reads to the frame-buffer read port.
- Drives 4-bit R/G/B plus hsync/vsync.
- Publishes vblank/frame_done so the rasterizer can schedule writes during vertical blanking.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_VISIBLE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch

Ports:
clk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
rd_en  out  1  frame-buffer read strobe, high for visible pixels only
rd_x  out  11  read column, 0..H_VISIBLE-1
rd_y  out  11  read row, 0..V_VISIBLE-1
rd_data  in  12  pixel word returned one cycle after rd_x/rd_y/rd_en; [3:0] R, [7:4] G, [11:8] B
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_hs  out  1  hsync, active-low
vga_vs  out  1  vsync, active-low
vblank  out  1  high while output line >= V_VISIBLE
frame_done  out  1  one-cycle pulse coincident with the last visible pixel (639,479) on vga_*

Behaviour:
- Counters:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
  - h_cnt increments every clk and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - Both counters are 11 bits unsigned; no other wrap points.
- Pipeline, with counters as stage 0:
  - Stage 1 registers: rd_en = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE); rd_x = h_cnt; rd_y = v_cnt. When rd_en=0, rd_x/rd_y hold the raw counter values (don't-care).
  - Stage 2: memory returns rd_data; active, hs and vs are delayed alongside it.
  - Stage 3 registers the outputs:
    - vga_r/g/b = active ? rd_data fields : 0.
    - vga_hs = !(h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]), i.e. 656..751.
    - vga_vs = !(v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]), i.e. 490..491.
  - Latency is fixed: counter value -> output 3 cycles; rd_x -> output 2 cycles. Sync and colour stay aligned at the outputs.
- Blanking: RGB is forced to 0 outside the visible area regardless of rd_data.
- Reset (any cycle, including mid-line or mid-frame):
  - Takes effect on the next edge: counters 0, all pipeline stages cleared.
  - rd_en=0, rd_x=0, rd_y=0, RGB=0, vga_hs=1, vga_vs=1, vblank=0, frame_done=0.
  - First clk with rst=0 counts (0,0); pixel (0,0) appears on the outputs 3 cycles later.
- vblank and frame_done are generated from delayed counters, so they are aligned with the outputs.
- No backpressure: rd_data is sampled unconditionally one cycle after the request.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: adds input test_mode (1 bit).
  - When test_mode=1, rd_en is held 0.
  - Visible RGB = eight vertical colour bars, each 80 px wide. Bar k = x/80, encoded as R=k[0]?F:0, G=k[1]?F:0, B=k[2]?F:0.
  - Latency and sync timing are unchanged.
- Undefined: no test_mode port; output is always memory-sourced.

Decomposition:
- Package vga_pkg holds:
  - the 640x480 timing constants and derived H_TOTAL/V_TOTAL;
  - pixel field positions (R 3:0, G 7:4, B 11:8) and the pixel word width (12);
  - the coordinate width (11).
- Sub-module vga_timing: counters plus raw active/hs/vs decode. vga_scanout adds the read port, delay pipeline and colour gating.

Test Plan:
- Reset, then release; behavioural memory holds 12'hABC at (0,0) -> rd_en=1, rd_x=0, rd_y=0 one cycle after release; 3 cycles after release vga_r=C, g=B, b=A, hs=1, vs=1.
- Free-run one line -> vga_hs low for exactly 96 clocks, starting 656 clocks after pixel 0 appears; line period 800 clocks.
- Free-run two frames -> vga_vs low for 2 lines (1600 clocks) starting at line 490; frame period 420000 clocks; frame_done pulses exactly once per frame, with vga_* showing (639,479); vblank high for 45 lines.
- Memory filled with 12'hFFF -> RGB 0 at all h>=640 and v>=480; rd_en never asserted outside the visible area.
- Assert rst for 1 cycle at h=300, v=200 -> next cycle all outputs at reset values; the following frame timing restarts from (0,0).
- With VGA_TEST_PATTERN_EN, test_mode=1 -> pixel x=85 gives R=F, G=0, B=0; x=639 gives R=G=B=F; rd_en stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, pixel word layout and shared types
// for the frame-buffer scanout path.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  // Vertical timing, in lines
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Pixel word layout: [3:0] R, [7:4] G, [11:8] B
  localparam int PIX_W   = 12;
  localparam int CH_W    = 4;
  localparam int R_LSB   = 0;
  localparam int G_LSB   = 4;
  localparam int B_LSB   = 8;

  // Counter / coordinate width
  localparam int COORD_W = 11;

  // Width of one test-pattern colour bar in pixels
  localparam int BAR_W_PX = 80;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0]   pixel_t;
  typedef logic [CH_W-1:0]    chan_t;

  // Per-pixel control flags travelling down the pipeline with the pixel.
  // hsync/vsync are "inside the sync pulse" (active-high here, inverted at
  // the pins); last marks the final visible pixel of the frame.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic vblank;
    logic last;
  } ctrl_t;

  // Colour-bar pixel for bar index k: each channel fully on when its bit is set
  function automatic pixel_t bar_pixel(input logic [2:0] k);
    pixel_t p;
    p = '0;
    p[R_LSB +: CH_W] = {CH_W{k[0]}};
    p[G_LSB +: CH_W] = {CH_W{k[1]}};
    p[B_LSB +: CH_W] = {CH_W{k[2]}};
    return p;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running horizontal/vertical pixel counters and the raw
// (undelayed) active / sync / blanking decode for the current counter value.
module vga_timing #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic            clk,
  input  logic            rst,
  output vga_pkg::coord_t h_cnt,
  output vga_pkg::coord_t v_cnt,
  output vga_pkg::ctrl_t  ctrl
);
  import vga_pkg::*;

  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam coord_t H_VIS_LAST = coord_t'(H_VISIBLE - 1);
  localparam coord_t V_VIS_LAST = coord_t'(V_VISIBLE - 1);

  // Raster counters: h wraps at end of line, v advances on that wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
    end else begin
      h_cnt <= h_cnt + coord_t'(1);
    end
  end

  // Decode the current counter position into pipeline control flags
  always_comb begin
    ctrl        = '0;
    ctrl.active = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    ctrl.hsync  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    ctrl.vsync  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    ctrl.vblank = (v_cnt >= V_VIS_C);
    ctrl.last   = (h_cnt == H_VIS_LAST) && (v_cnt == V_VIS_LAST);
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: reads the frame buffer in raster order and drives a VGA port.
// Pipeline: stage 0 counters, stage 1 read request, stage 2 memory returns
// rd_data, stage 3 output registers. Counter -> pins latency is 3 clocks.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input that
// replaces memory pixels with eight vertical colour bars.
//
// Read port: rd_en/rd_x/rd_y form a request that is valid whenever rd_en=1;
// there is no ready. The memory must return the addressed word on rd_data
// exactly one clock later, and rd_data is sampled unconditionally.
module vga_scanout #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic            clk,
  input  logic            rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic            test_mode,
`endif
  output logic            rd_en,
  output vga_pkg::coord_t rd_x,
  output vga_pkg::coord_t rd_y,
  input  vga_pkg::pixel_t rd_data,
  output vga_pkg::chan_t  vga_r,
  output vga_pkg::chan_t  vga_g,
  output vga_pkg::chan_t  vga_b,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            vblank,
  output logic            frame_done
);
  import vga_pkg::*;

  coord_t h_cnt;
  coord_t v_cnt;
  ctrl_t  ctrl0;
  ctrl_t  ctrl1;
  ctrl_t  ctrl2;
  pixel_t px;

`ifdef VGA_TEST_PATTERN_EN
  logic       tm1;
  logic       tm2;
  logic [2:0] bar2;
`endif

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .clk   (clk),
    .rst   (rst),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .ctrl  (ctrl0)
  );

  // Stage 1: issue the frame-buffer read and capture the control flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en <= 1'b0;
      rd_x  <= '0;
      rd_y  <= '0;
      ctrl1 <= '0;
`ifdef VGA_TEST_PATTERN_EN
      tm1   <= 1'b0;
`endif
    end else begin
`ifdef VGA_TEST_PATTERN_EN
      rd_en <= ctrl0.active && !test_mode;
      tm1   <= test_mode;
`else
      rd_en <= ctrl0.active;
`endif
      rd_x  <= h_cnt;
      rd_y  <= v_cnt;
      ctrl1 <= ctrl0;
    end
  end

  // Stage 2: delay control alongside the memory access
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl2 <= '0;
`ifdef VGA_TEST_PATTERN_EN
      tm2   <= 1'b0;
      bar2  <= '0;
`endif
    end else begin
      ctrl2 <= ctrl1;
`ifdef VGA_TEST_PATTERN_EN
      tm2   <= tm1;
      bar2  <= 3'(rd_x / coord_t'(BAR_W_PX));
`endif
    end
  end

  // Pixel source select: memory word, or the colour bar in test mode
  always_comb begin
    px = rd_data;
`ifdef VGA_TEST_PATTERN_EN
    if (tm2) px = bar_pixel(bar2);
`endif
  end

  // Stage 3: output registers with blanking and active-low syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      vblank     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vga_r      <= ctrl2.active ? px[R_LSB +: CH_W] : '0;
      vga_g      <= ctrl2.active ? px[G_LSB +: CH_W] : '0;
      vga_b      <= ctrl2.active ? px[B_LSB +: CH_W] : '0;
      vga_hs     <= !ctrl2.hsync;
      vga_vs     <= !ctrl2.vsync;
      vblank     <= ctrl2.vblank;
      frame_done <= ctrl2.last;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: two instances share one clock -- one at full 640x480
// timing (line-level behaviour) and one with a shrunken raster so whole
// frames fit in a short run. Expected outputs come from a raster-index
// model: after e clocks out of reset the outputs show pixel number e-3
// and the read port requests pixel number e-1.
module tb_vga_scanout;

  typedef struct packed {
    int hv; int hf; int hsy; int hb; int vv; int vf; int vsy; int vb;
  } tcfg_t;

  localparam tcfg_t CFG_BIG = '{hv:640, hf:16, hsy:96, hb:48, vv:480, vf:10, vsy:2, vb:33};
  localparam tcfg_t CFG_SML = '{hv:40,  hf:4,  hsy:8,  hb:6,  vv:12,  vf:2,  vsy:2, vb:3};

  typedef struct packed {
    logic        rd_en;
    logic [10:0] rd_x;
    logic [10:0] rd_y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs;
    logic        vs;
    logic        vbl;
    logic        fd;
  } obs_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic b_rst = 1'b1;
  logic s_rst = 1'b1;

  // big instance signals
  logic        b_rd_en, b_vga_hs, b_vga_vs, b_vblank, b_frame_done;
  logic [10:0] b_rd_x, b_rd_y;
  logic [11:0] b_rd_data;
  logic [3:0]  b_vga_r, b_vga_g, b_vga_b;
  // small instance signals
  logic        s_rd_en, s_vga_hs, s_vga_vs, s_vblank, s_frame_done;
  logic [10:0] s_rd_x, s_rd_y;
  logic [11:0] s_rd_data;
  logic [3:0]  s_vga_r, s_vga_g, s_vga_b;
`ifdef VGA_TEST_PATTERN_EN
  logic b_tm = 1'b0;
  logic s_tm = 1'b0;
`endif

  // stimulus / model state
  int unsigned seed = 0;
  bit          fill = 1'b0;
  bit          tm_big = 1'b0;
  int          big_e = 0;
  int          sm_e = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // measurement state
  int b_hs_fall[$];
  int b_hs_width[$];
  int s_fd_at[$];
  int s_vs_fall[$];
  int s_vs_width[$];
  int s_vb_rise[$];
  int s_vb_width[$];
  bit prev_b_hs, prev_s_vs, prev_s_vb;
  int b_rd_hits, b_rd_out, b_rgb_out, s_rd_out, s_rgb_out;

  vga_scanout u_big (
    .clk        (clk),
    .rst        (b_rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode  (b_tm),
`endif
    .rd_en      (b_rd_en),
    .rd_x       (b_rd_x),
    .rd_y       (b_rd_y),
    .rd_data    (b_rd_data),
    .vga_r      (b_vga_r),
    .vga_g      (b_vga_g),
    .vga_b      (b_vga_b),
    .vga_hs     (b_vga_hs),
    .vga_vs     (b_vga_vs),
    .vblank     (b_vblank),
    .frame_done (b_frame_done)
  );

  vga_scanout #(
    .H_VISIBLE (CFG_SML.hv), .H_FP (CFG_SML.hf), .H_SYNC (CFG_SML.hsy), .H_BP (CFG_SML.hb),
    .V_VISIBLE (CFG_SML.vv), .V_FP (CFG_SML.vf), .V_SYNC (CFG_SML.vsy), .V_BP (CFG_SML.vb)
  ) u_small (
    .clk        (clk),
    .rst        (s_rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode  (s_tm),
`endif
    .rd_en      (s_rd_en),
    .rd_x       (s_rd_x),
    .rd_y       (s_rd_y),
    .rd_data    (s_rd_data),
    .vga_r      (s_vga_r),
    .vga_g      (s_vga_g),
    .vga_b      (s_vga_b),
    .vga_hs     (s_vga_hs),
    .vga_vs     (s_vga_vs),
    .vblank     (s_vblank),
    .frame_done (s_frame_done)
  );

  // frame-buffer contents
  function automatic logic [11:0] pix(input int x, input int y);
    if (fill) return 12'hFFF;
    if (x == 0 && y == 0) return 12'hABC;
    return 12'(x * 37 + y * 101 + int'(seed));
  endfunction

  // behavioural frame buffers: one-cycle read latency, junk when not read
  always @(posedge clk) begin
    b_rd_data <= b_rd_en ? pix(int'(b_rd_x), int'(b_rd_y)) : 12'($urandom);
    s_rd_data <= s_rd_en ? pix(int'(s_rd_x), int'(s_rd_y)) : 12'($urandom);
  end

  function automatic int htot(input tcfg_t c);
    return c.hv + c.hf + c.hsy + c.hb;
  endfunction

  function automatic int vtot(input tcfg_t c);
    return c.vv + c.vf + c.vsy + c.vb;
  endfunction

  function automatic bit vis(input tcfg_t c, input int n);
    int h, v;
    if (n < 0) return 1'b0;
    h = n % htot(c);
    v = (n / htot(c)) % vtot(c);
    return (h < c.hv) && (v < c.vv);
  endfunction

  // reference: e clocks since reset released
  function automatic obs_t model(input tcfg_t c, input int e, input bit tm);
    obs_t o;
    int n, h, v, k;
    logic [11:0] p;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (e >= 1) begin
      n = e - 1;
      h = n % htot(c);
      v = (n / htot(c)) % vtot(c);
      o.rd_x  = 11'(h);
      o.rd_y  = 11'(v);
      o.rd_en = (h < c.hv) && (v < c.vv) && !tm;
    end
    if (e >= 3) begin
      n = e - 3;
      h = n % htot(c);
      v = (n / htot(c)) % vtot(c);
      if ((h < c.hv) && (v < c.vv)) begin
        if (tm) begin
          k = h / 80;
          o.r = k[0] ? 4'hF : 4'h0;
          o.g = k[1] ? 4'hF : 4'h0;
          o.b = k[2] ? 4'hF : 4'h0;
        end else begin
          p = pix(h, v);
          o.r = p[3:0];
          o.g = p[7:4];
          o.b = p[11:8];
        end
      end
      o.hs  = !((h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hsy));
      o.vs  = !((v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vsy));
      o.vbl = (v >= c.vv);
      o.fd  = (h == c.hv - 1) && (v == c.vv - 1);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    if (b_rst) big_e = 0; else big_e++;
    if (s_rst) sm_e = 0; else sm_e++;
    #1;
  endtask

  task automatic check_both();
    obs_t eo, oo;
    eo = model(CFG_BIG, big_e, tm_big);
    oo = '{b_rd_en, b_rd_x, b_rd_y, b_vga_r, b_vga_g, b_vga_b, b_vga_hs, b_vga_vs, b_vblank, b_frame_done};
    chk($sformatf("big_cycle_%0d", big_e), 64'(oo), 64'(eo));
    eo = model(CFG_SML, sm_e, 1'b0);
    oo = '{s_rd_en, s_rd_x, s_rd_y, s_vga_r, s_vga_g, s_vga_b, s_vga_hs, s_vga_vs, s_vblank, s_frame_done};
    chk($sformatf("small_cycle_%0d", sm_e), 64'(oo), 64'(eo));
  endtask

  task automatic track();
    if (prev_b_hs && !b_vga_hs) b_hs_fall.push_back(big_e);
    if (!prev_b_hs && b_vga_hs && b_hs_fall.size() > 0) b_hs_width.push_back(big_e - b_hs_fall[$]);
    prev_b_hs = b_vga_hs;
    if (b_rd_en) b_rd_hits++;
    if (b_rd_en && !vis(CFG_BIG, big_e - 1)) b_rd_out++;
    if ({b_vga_r, b_vga_g, b_vga_b} != 12'h000 && !vis(CFG_BIG, big_e - 3)) b_rgb_out++;

    if (s_frame_done) s_fd_at.push_back(sm_e);
    if (prev_s_vs && !s_vga_vs) s_vs_fall.push_back(sm_e);
    if (!prev_s_vs && s_vga_vs && s_vs_fall.size() > 0) s_vs_width.push_back(sm_e - s_vs_fall[$]);
    prev_s_vs = s_vga_vs;
    if (!prev_s_vb && s_vblank) s_vb_rise.push_back(sm_e);
    if (prev_s_vb && !s_vblank && s_vb_rise.size() > 0) s_vb_width.push_back(sm_e - s_vb_rise[$]);
    prev_s_vb = s_vblank;
    if (s_rd_en && !vis(CFG_SML, sm_e - 1)) s_rd_out++;
    if ({s_vga_r, s_vga_g, s_vga_b} != 12'h000 && !vis(CFG_SML, sm_e - 3)) s_rgb_out++;
  endtask

  task automatic clear_big();
    b_hs_fall.delete();
    b_hs_width.delete();
    prev_b_hs = 1'b1;
    b_rd_hits = 0;
    b_rd_out  = 0;
    b_rgb_out = 0;
  endtask

  task automatic clear_small();
    s_fd_at.delete();
    s_vs_fall.delete();
    s_vs_width.delete();
    s_vb_rise.delete();
    s_vb_width.delete();
    prev_s_vs = 1'b1;
    prev_s_vb = 1'b0;
    s_rd_out  = 0;
    s_rgb_out = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_both();
      track();
    end
  endtask

  initial begin
    // ---- power-on reset, random frame-buffer contents ----
    seed   = $urandom_range(0, 4095);
    fill   = 1'b0;
    tm_big = 1'b0;
    b_rst  = 1'b1;
    s_rst  = 1'b1;
    clear_big();
    clear_small();
    run(2);
    chk("reset_hs", 64'(b_vga_hs), 64'(1));
    chk("reset_vs", 64'(b_vga_vs), 64'(1));
    chk("reset_rd_en", 64'(b_rd_en), 64'(0));

    // ---- release: first request and first pixel ----
    b_rst = 1'b0;
    s_rst = 1'b0;
    clear_big();
    clear_small();
    run(1);
    chk("first_rd_en", 64'(b_rd_en), 64'(1));
    chk("first_rd_x", 64'(b_rd_x), 64'(0));
    chk("first_rd_y", 64'(b_rd_y), 64'(0));
    run(2);
    chk("pix00_r", 64'(b_vga_r), 64'(4'hC));
    chk("pix00_g", 64'(b_vga_g), 64'(4'hB));
    chk("pix00_b", 64'(b_vga_b), 64'(4'hA));
    chk("pix00_hs", 64'(b_vga_hs), 64'(1));
    chk("pix00_vs", 64'(b_vga_vs), 64'(1));

    // ---- free run: three full-size lines, two small frames ----
    run(2397);
    chk("big_hs_fall0", 64'(qget(b_hs_fall, 0)), 64'(3 + CFG_BIG.hv + CFG_BIG.hf));
    chk("big_line_period", 64'(qget(b_hs_fall, 1) - qget(b_hs_fall, 0)), 64'(htot(CFG_BIG)));
    chk("big_hs_width", 64'(qget(b_hs_width, 0)), 64'(CFG_BIG.hsy));
    chk("sml_fd_count", 64'(s_fd_at.size()), 64'(2));
    chk("sml_fd0", 64'(qget(s_fd_at, 0)), 64'(3 + (CFG_SML.vv - 1) * htot(CFG_SML) + CFG_SML.hv - 1));
    chk("sml_frame_period", 64'(qget(s_fd_at, 1) - qget(s_fd_at, 0)), 64'(htot(CFG_SML) * vtot(CFG_SML)));
    chk("sml_vs_fall0", 64'(qget(s_vs_fall, 0)), 64'(3 + (CFG_SML.vv + CFG_SML.vf) * htot(CFG_SML)));
    chk("sml_vs_width", 64'(qget(s_vs_width, 0)), 64'(CFG_SML.vsy * htot(CFG_SML)));
    chk("sml_vb_rise0", 64'(qget(s_vb_rise, 0)), 64'(3 + CFG_SML.vv * htot(CFG_SML)));
    chk("sml_vb_width", 64'(qget(s_vb_width, 0)), 64'((vtot(CFG_SML) - CFG_SML.vv) * htot(CFG_SML)));
    chk("big_rd_outside", 64'(b_rd_out), 64'(0));
    chk("sml_rd_outside", 64'(s_rd_out), 64'(0));

    // ---- one-cycle reset mid-line on the full-size instance (h=300) ----
    for (int i = 0; i < htot(CFG_BIG); i++) begin
      if (big_e % htot(CFG_BIG) == 300) break;
      run(1);
    end
    b_rst = 1'b1;
    run(1);
    chk("mid_rst_big_rd_en", 64'(b_rd_en), 64'(0));
    chk("mid_rst_big_rd_x", 64'(b_rd_x), 64'(0));
    chk("mid_rst_big_hs", 64'(b_vga_hs), 64'(1));
    b_rst = 1'b0;
    clear_big();

    // ---- one-cycle reset mid-frame on the small instance (h=30, v=7) ----
    for (int i = 0; i < htot(CFG_SML) * vtot(CFG_SML); i++) begin
      if (sm_e % htot(CFG_SML) == 30 && (sm_e / htot(CFG_SML)) % vtot(CFG_SML) == 7) break;
      run(1);
    end
    s_rst = 1'b1;
    run(1);
    chk("mid_rst_sml_rgb", 64'({s_vga_r, s_vga_g, s_vga_b}), 64'(0));
    chk("mid_rst_sml_vblank", 64'(s_vblank), 64'(0));
    chk("mid_rst_sml_rd_y", 64'(s_rd_y), 64'(0));
    s_rst = 1'b0;
    clear_small();
    run(1200);
    chk("restart_big_hs_fall0", 64'(qget(b_hs_fall, 0)), 64'(3 + CFG_BIG.hv + CFG_BIG.hf));
    chk("restart_sml_fd0", 64'(qget(s_fd_at, 0)), 64'(3 + (CFG_SML.vv - 1) * htot(CFG_SML) + CFG_SML.hv - 1));
    chk("restart_sml_vs_fall0", 64'(qget(s_vs_fall, 0)), 64'(3 + (CFG_SML.vv + CFG_SML.vf) * htot(CFG_SML)));

    // ---- all-white frame buffer: blanking must still force black ----
    b_rst = 1'b1;
    s_rst = 1'b1;
    run(1);
    fill = 1'b1;
    run(1);
    b_rst = 1'b0;
    s_rst = 1'b0;
    clear_big();
    clear_small();
    run(2400);
    chk("white_big_rgb_outside", 64'(b_rgb_out), 64'(0));
    chk("white_sml_rgb_outside", 64'(s_rgb_out), 64'(0));
    chk("white_sml_rd_outside", 64'(s_rd_out), 64'(0));
    chk("white_big_rd_outside", 64'(b_rd_out), 64'(0));

`ifdef VGA_TEST_PATTERN_EN
    // ---- colour bars on the full-size instance ----
    b_rst  = 1'b1;
    run(1);
    b_tm   = 1'b1;
    tm_big = 1'b1;
    run(1);
    b_rst  = 1'b0;
    clear_big();
    run(88);
    chk("bar_x85_r", 64'(b_vga_r), 64'(4'hF));
    chk("bar_x85_g", 64'(b_vga_g), 64'(4'h0));
    chk("bar_x85_b", 64'(b_vga_b), 64'(4'h0));
    run(554);
    chk("bar_x639_rgb", 64'({b_vga_r, b_vga_g, b_vga_b}), 64'(12'hFFF));
    run(200);
    chk("bar_rd_en_hits", 64'(b_rd_hits), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
